// File: rtl/md5_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : md5_job_sched
// Brief    : Job queue and AXI read-burst sequencer for the MD5 streaming
//            datapath. Optional job cycle counter under MD5_JOB_SCHED_PERF_EN.
// Revision : 1.0
// ============================================================================
module md5_job_sched #(
    parameter int QLOG     = 2,
    parameter int MAX_CRED = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        softreg_req_valid,
    input  logic        softreg_req_isWrite,
    input  logic [31:0] softreg_req_addr,
    input  logic [63:0] softreg_req_data,
    output logic        softreg_resp_valid,
    output logic [63:0] softreg_resp_data,
    output logic [15:0] arid_m,
    output logic [63:0] araddr_m,
    output logic [7:0]  arlen_m,
    output logic [2:0]  arsize_m,
    output logic        arvalid_m,
    input  logic        arready_m,
    input  logic        rvalid_m,
    input  logic        rready_m,
    input  logic        rlast_m,
    output logic        job_start,
    output logic        job_done,
    output logic        busy
);

    localparam int c_QDEPTH = 1 << QLOG;
    localparam int c_CW     = $clog2(MAX_CRED + 1);
    localparam logic [c_CW-1:0] c_MAX_CRED = c_CW'(MAX_CRED);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    logic [1:0]      r_state;
    logic [63:0]     r_q_addr  [c_QDEPTH];
    logic [63:0]     r_q_words [c_QDEPTH];
    logic [QLOG-1:0] r_wp, r_rp;
    logic [QLOG:0]   r_qcnt;
    logic [63:0]     r_cur_addr, r_words_left, r_staged, r_done_cnt;
    logic [c_CW-1:0] r_credits, r_cred_limit;
    logic            r_ovf, r_job_done, r_resp_valid;
    logic [63:0]     r_resp_data;

    logic            w_wr, w_rd, w_q_empty, w_q_full, w_pop, w_push_req, w_push_ok;
    logic            w_arvalid, w_ar_hs, w_r_done, w_drain_done, w_cred_wr, w_clr;
    logic [6:0]      w_room, w_len;
    logic [c_CW-1:0] w_cred_val;
    logic [63:0]     w_perf, w_rd_data;

    assign w_wr       = softreg_req_valid && softreg_req_isWrite;
    assign w_rd       = softreg_req_valid && !softreg_req_isWrite;
    assign w_q_empty  = (r_qcnt == '0);
    assign w_q_full   = (r_qcnt == (QLOG+1)'(c_QDEPTH));
    assign w_pop      = (r_state == c_ST_LOAD);
    assign w_push_req = w_wr && (softreg_req_addr == 32'h38);
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign w_push_ok  = w_push_req && (!w_q_full || w_pop);
    assign w_clr      = w_wr && (softreg_req_addr == 32'h60);
    assign w_cred_wr  = w_wr && (softreg_req_addr == 32'h50) && (r_state == c_ST_IDLE);
    assign w_cred_val = (softreg_req_data > 64'(MAX_CRED)) ? c_MAX_CRED : softreg_req_data[c_CW-1:0];

    // Bursts never cross a 4 KiB page: cap at the beats left in the current page.
    assign w_room       = 7'd64 - {1'b0, r_cur_addr[11:6]};
    assign w_len        = (r_words_left < 64'(w_room)) ? r_words_left[6:0] : w_room;
    assign w_arvalid    = (r_state == c_ST_ISSUE) && (r_words_left != '0) && (r_credits != '0);
    assign w_ar_hs      = w_arvalid && arready_m;
    assign w_r_done     = rvalid_m && rready_m && rlast_m;
    assign w_drain_done = (r_state == c_ST_DRAIN) && (r_credits == r_cred_limit);

    assign arid_m             = '0;
    assign arsize_m           = 3'b110;
    assign arvalid_m          = w_arvalid;
    assign araddr_m           = w_arvalid ? r_cur_addr : '0;
    assign arlen_m            = w_arvalid ? ({1'b0, w_len} - 8'd1) : '0;
    assign job_start          = w_pop;
    assign job_done           = r_job_done;
    assign busy               = (r_state != c_ST_IDLE);
    assign softreg_resp_valid = r_resp_valid;
    assign softreg_resp_data  = r_resp_data;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_q_addr[r_wp]  <= r_staged;
            r_q_words[r_wp] <= softreg_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_qcnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + QLOG'(1);
            if (w_pop)     r_rp <= r_rp + QLOG'(1);
            if (w_push_ok && !w_pop)      r_qcnt <= r_qcnt + (QLOG+1)'(1);
            else if (!w_push_ok && w_pop) r_qcnt <= r_qcnt - (QLOG+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cur_addr   <= '0;
            r_words_left <= '0;
            r_job_done   <= 1'b0;
        end else begin
            r_job_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: if (!w_q_empty) r_state <= c_ST_LOAD;
                c_ST_LOAD: begin
                    r_cur_addr   <= r_q_addr[r_rp];
                    r_words_left <= r_q_words[r_rp];
                    r_state      <= (r_q_words[r_rp] != '0) ? c_ST_ISSUE : c_ST_DRAIN;
                end
                c_ST_ISSUE: if (w_ar_hs) begin
                    r_cur_addr   <= r_cur_addr + 64'({w_len, 6'b0});
                    r_words_left <= r_words_left - 64'(w_len);
                    if (r_words_left == 64'(w_len)) r_state <= c_ST_DRAIN;
                end
                default: if (w_drain_done) begin
                    r_job_done <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Returns saturate at the limit so stray beats after a reset are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits    <= c_MAX_CRED;
            r_cred_limit <= c_MAX_CRED;
        end else if (w_cred_wr) begin
            r_credits    <= w_cred_val;
            r_cred_limit <= w_cred_val;
        end else if (w_ar_hs && !w_r_done) begin
            r_credits <= r_credits - c_CW'(1);
        end else if (w_r_done && !w_ar_hs && (r_credits < r_cred_limit)) begin
            r_credits <= r_credits + c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_staged   <= '0;
            r_ovf      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_wr && (softreg_req_addr == 32'h30)) r_staged <= {softreg_req_data[63:6], 6'b0};
            if (w_clr)                          r_ovf <= 1'b0;
            else if (w_push_req && !w_push_ok)  r_ovf <= 1'b1;
            if (w_clr)             r_done_cnt <= '0;
            else if (w_drain_done) r_done_cnt <= r_done_cnt + 64'd1;
        end
    end

`ifdef MD5_JOB_SCHED_PERF_EN
    logic [63:0] r_perf_cnt, r_perf_last;

    // The LOAD cycle counts as the first cycle of the job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt  <= '0;
            r_perf_last <= '0;
        end else begin
            if (w_pop)                       r_perf_cnt <= 64'd1;
            else if (r_state != c_ST_IDLE)   r_perf_cnt <= r_perf_cnt + 64'd1;
            if (w_drain_done)                r_perf_last <= r_perf_cnt + 64'd1;
        end
    end
    assign w_perf = r_perf_last;
`else
    assign w_perf = '0;
`endif

    always_comb begin
        w_rd_data = '0;
        case (softreg_req_addr)
            32'h40:  w_rd_data = {56'b0, r_ovf, w_q_full, w_q_empty, 3'b0, r_state};
            32'h48:  w_rd_data = r_done_cnt;
            32'h58:  w_rd_data = w_perf;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_rd;
            r_resp_data  <= w_rd ? w_rd_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md5_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_job_sched
// Brief    : Bench for md5_job_sched: job-queue model with expected burst
//            lists, credit accounting and directed plus random jobs.
// Revision : 1.0
// ============================================================================
module tb_md5_job_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_isWrite;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [15:0] arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        job_start, job_done, busy;

    always #5 clk = ~clk;

    md5_job_sched dut (
        .clk(clk), .rst(rst),
        .softreg_req_valid(req_valid), .softreg_req_isWrite(req_isWrite),
        .softreg_req_addr(req_addr), .softreg_req_data(req_data),
        .softreg_resp_valid(resp_valid), .softreg_resp_data(resp_data),
        .arid_m(arid), .araddr_m(araddr), .arlen_m(arlen), .arsize_m(arsize),
        .arvalid_m(arvalid), .arready_m(arready),
        .rvalid_m(rvalid), .rready_m(rready), .rlast_m(rlast),
        .job_start(job_start), .job_done(job_done), .busy(busy)
    );

    typedef struct { logic [63:0] addr; logic [63:0] words; } job_t;
    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;

    job_t pend_q[$];
    ar_t  exp_ar[$];
    ar_t  ar_log[$];
    int   rq[$];
    int   total = 0, bad = 0, cyc = 0;
    int   ar_mode = 1, tokens = -1, lat_max = 6;
    int   outstanding = 0, limit_m = 8, done_m = 0;
    bit   ovf_m = 0, active = 0, prev_rd = 0, prev_stall = 0;
    logic [63:0] staged_m = '0, prev_addr = '0;
    logic [7:0]  prev_len = '0;
    int   ar_total = 0, r_total = 0;
    int   last_ar_cyc = 0, last_r_cyc = 0, last_start_cyc = 0, last_done_cyc = 0, last_push_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected bursts from the job rules: split at every 4 KiB page, at most 64 beats.
    function automatic void gen_bursts(input logic [63:0] a, input logic [63:0] w);
        logic [63:0] room, len;
        while (w != 0) begin
            room = (64'd4096 - (a % 64'd4096)) / 64'd64;
            len  = (w < room) ? w : room;
            exp_ar.push_back('{a, 8'(len - 64'd1)});
            a = a + len * 64'd64;
            w = w - len;
        end
    endfunction

    // AXI slave: arready policy plus one rlast beat per accepted burst after a latency.
    initial begin
        arready = 0; rvalid = 0; rready = 0; rlast = 0;
        forever begin
            @(posedge clk); #1;
            case (ar_mode)
                0:       arready = 1'b0;
                1:       arready = 1'b1;
                default: arready = ($urandom_range(0, 3) != 0);
            endcase
            if (rq.size() > 0 && tokens != 0 && cyc >= rq[0]) begin
                rvalid = 1'b1; rlast = 1'b1; rready = ($urandom_range(0, 3) != 0);
            end else begin
                rvalid = 1'($urandom_range(0, 1)); rlast = 1'b0; rready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor and model update, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete(); exp_ar.delete(); rq.delete();
            outstanding = 0; limit_m = 8; done_m = 0; ovf_m = 0; active = 0;
            staged_m = '0; prev_rd = 0; prev_stall = 0;
        end else begin
            check("arid", arid, 0);
            check("arsize", arsize, 6);
            check("resp_valid_timing", resp_valid, prev_rd);
            prev_rd = req_valid && !req_isWrite;
            if (prev_stall) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, prev_addr);
                check("ar_hold_len", arlen, prev_len);
            end
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            prev_len   = arlen;
            if (arvalid) check("credit_bound", outstanding < limit_m, 1);
            if (job_done) begin
                check("done_while_active", active, 1);
                check("done_bursts_left", exp_ar.size(), 0);
                check("done_outstanding", outstanding, 0);
                active = 0; done_m++; last_done_cyc = cyc;
            end
            if (job_start) begin
                job_t j;
                check("start_queue_nonempty", pend_q.size() != 0, 1);
                check("start_while_idle", active, 0);
                if (pend_q.size() != 0) begin
                    j = pend_q.pop_front();
                    exp_ar.delete();
                    gen_bursts(j.addr, j.words);
                end
                active = 1; last_start_cyc = cyc;
            end
            if (arvalid && arready) begin
                ar_t e;
                check("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) begin
                    e = exp_ar.pop_front();
                    check("ar_addr", araddr, e.addr);
                    check("ar_len", arlen, e.len);
                end
                ar_log.push_back('{araddr, arlen});
                outstanding++;
                rq.push_back(cyc + $urandom_range(1, lat_max));
                ar_total++; last_ar_cyc = cyc;
            end
            if (rvalid && rready && rlast) begin
                if (rq.size() != 0) void'(rq.pop_front());
                outstanding--;
                if (tokens > 0) tokens--;
                r_total++; last_r_cyc = cyc;
            end
            if (req_valid && req_isWrite) begin
                case (req_addr)
                    32'h30: staged_m = {req_data[63:6], 6'b0};
                    32'h38: begin
                        last_push_cyc = cyc;
                        if (pend_q.size() < 4) pend_q.push_back('{staged_m, req_data});
                        else ovf_m = 1;
                    end
                    32'h50: if (!active && pend_q.size() == 0) limit_m = (req_data > 64'd8) ? 8 : int'(req_data);
                    32'h60: begin ovf_m = 0; done_m = 0; end
                    default: ;
                endcase
            end
        end
    end

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        req_valid = 1; req_isWrite = 1; req_addr = a; req_data = d;
        @(posedge clk); #1;
        req_valid = 0; req_isWrite = 0;
    endtask

    task automatic sr_read(input logic [31:0] a, input logic [63:0] exp, input string name);
        @(posedge clk); #1;
        req_valid = 1; req_isWrite = 0; req_addr = a;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        check({name, "_valid"}, resp_valid, 1);
        check(name, resp_data, exp);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        @(posedge clk);
        while ((pend_q.size() != 0 || active) && n < budget) begin
            @(posedge clk); n++;
        end
        check({name, "_timeout"}, n < budget, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_count(input int sel, input int target, input int budget, input string name);
        int n = 0;
        while (((sel == 0) ? ar_total : r_total) < target && n < budget) begin
            @(posedge clk); n++;
        end
        check({name, "_timeout"}, n < budget, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_arvalid"}, arvalid, 0);
        check({name, "_araddr"}, araddr, 0);
        check({name, "_arlen"}, arlen, 0);
        check({name, "_job_start"}, job_start, 0);
        check({name, "_job_done"}, job_done, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_resp_valid"}, resp_valid, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, n0;
        logic [63:0] ra;
        rst = 1; req_valid = 0; req_isWrite = 0; req_addr = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_idle_outputs("reset");
        sr_read(32'h40, 64'h20, "status_reset");
        sr_read(32'h48, 64'h0, "done_reset");

        // 128 words from a page start: two full bursts.
        n0 = ar_log.size();
        sr_write(32'h30, 64'h1000);
        sr_write(32'h38, 64'd128);
        wait_quiet(500, "t1");
        check("t1_start_latency", last_start_cyc - last_push_cyc, 2);
        check("t1_ar_count", ar_log.size() - n0, 2);
        check("t1_ar0_addr", ar_log[n0].addr, 64'h1000);
        check("t1_ar0_len", ar_log[n0].len, 63);
        check("t1_ar1_addr", ar_log[n0+1].addr, 64'h2000);
        check("t1_ar1_len", ar_log[n0+1].len, 63);
        check("t1_done_after_rlast", last_done_cyc - last_r_cyc, 2);
        check("t1_model_done", done_m, 1);
        sr_read(32'h48, 64'd1, "t1_done_cnt");

        // Page split, with low address bits set in the staging write.
        n0 = ar_log.size();
        sr_write(32'h30, 64'h1FFF);
        sr_write(32'h38, 64'd3);
        wait_quiet(500, "t2");
        check("t2_ar0_addr", ar_log[n0].addr, 64'h1FC0);
        check("t2_ar0_len", ar_log[n0].len, 0);
        check("t2_ar1_addr", ar_log[n0+1].addr, 64'h2000);
        check("t2_ar1_len", ar_log[n0+1].len, 1);

        // Address wrap at 2^64.
        n0 = ar_log.size();
        sr_write(32'h30, 64'hFFFF_FFFF_FFFF_FF80);
        sr_write(32'h38, 64'd4);
        wait_quiet(500, "twrap");
        check("twrap_ar0_addr", ar_log[n0].addr, 64'hFFFF_FFFF_FFFF_FF80);
        check("twrap_ar0_len", ar_log[n0].len, 1);
        check("twrap_ar1_addr", ar_log[n0+1].addr, 64'h0);
        check("twrap_ar1_len", ar_log[n0+1].len, 1);

        // Credit limit of 2 with returns withheld.
        sr_write(32'h50, 64'd2);
        tokens = 0; a0 = ar_total;
        sr_write(32'h30, 64'h0);
        sr_write(32'h38, 64'd256);
        repeat (40) @(posedge clk);
        check("t3_ar_capped", ar_total - a0, 2);
        @(negedge clk);
        check("t3_arvalid_low", arvalid, 0);
        check("t3_busy", busy, 1);
        sr_write(32'h50, 64'd8);
        repeat (5) @(posedge clk);
        check("t3_busy_write_ignored", ar_total - a0, 2);
        r0 = r_total; tokens = 1;
        wait_count(1, r0 + 1, 100, "t3_release");
        wait_count(0, a0 + 3, 100, "t3_next_ar");
        check("t3_ar_after_release", last_ar_cyc - last_r_cyc, 1);
        repeat (10) @(posedge clk);
        check("t3_one_more_only", ar_total - a0, 3);
        tokens = -1;
        wait_quiet(3000, "t3");
        sr_write(32'h50, 64'd100);

        // Overflow: one job stalled in ISSUE, then five pushes.
        ar_mode = 0;
        sr_write(32'h30, 64'h40000);
        sr_write(32'h38, 64'd1);
        repeat (6) @(posedge clk);
        sr_write(32'h60, 64'h0);
        for (int i = 0; i < 5; i++) begin
            sr_write(32'h30, 64'(i + 1) * 64'h10000);
            sr_write(32'h38, 64'(i + 1));
        end
        check("t4_model_ovf", ovf_m, 1);
        check("t4_model_pending", pend_q.size(), 4);
        sr_read(32'h40, 64'hC2, "t4_status");
        ar_mode = 2;
        wait_quiet(3000, "t4");
        check("t4_model_done", done_m, 5);
        sr_read(32'h48, 64'd5, "t4_done_cnt");
        sr_read(32'h40, 64'hA0, "t4_status_idle");
        sr_write(32'h60, 64'h0);
        sr_read(32'h40, 64'h20, "t4_status_clr");
        sr_read(32'h48, 64'h0, "t4_done_clr");

        // Zero-word job.
        ar_mode = 1; a0 = ar_total;
        sr_write(32'h30, 64'h8000);
        sr_write(32'h38, 64'd0);
        wait_quiet(100, "t5");
        check("t5_done_gap", last_done_cyc - last_start_cyc, 2);
        check("t5_no_ar", ar_total - a0, 0);
`ifdef MD5_JOB_SCHED_PERF_EN
        sr_read(32'h58, 64'd2, "t5_perf");
`else
        sr_read(32'h58, 64'd0, "t5_perf");
`endif
        sr_read(32'h10, 64'd0, "unmapped_read");

        // Reset while one burst is outstanding.
        tokens = 0; a0 = ar_total;
        sr_write(32'h30, 64'h0);
        sr_write(32'h38, 64'd256);
        wait_count(0, a0 + 1, 60, "t6_first_ar");
        ar_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0; tokens = -1;
        @(negedge clk);
        check_idle_outputs("t6");
        sr_read(32'h40, 64'h20, "t6_status");
        sr_read(32'h48, 64'h0, "t6_done_cnt");

        // Random jobs, random arready and return latency, occasional credit changes.
        ar_mode = 2; lat_max = 12;
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 4) == 0) begin
                wait_quiet(5000, "rnd_quiet");
                sr_write(32'h50, 64'($urandom_range(1, 12)));
            end
            ra = {32'($urandom), 32'($urandom)};
            ra[5:0] = '0;
            sr_write(32'h30, ra);
            sr_write(32'h38, 64'($urandom_range(0, 150)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        wait_quiet(20000, "rnd");
        sr_read(32'h48, 64'(done_m), "rnd_done_cnt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
